shift_vector: RTL and testbench
===============================

// Module: shift_vector
//
// PURPOSE
// - Parametrised successor to the expression-buffer vector. Holds an ordered list of DATA_COUNT
//   words and supports get/set/insert/remove/clear at an arbitrary index.
// - Adds a valid/ready command handshake, a done/err response and range checking.
// - Shifts at one element per cycle through a pipelined synchronous-read RAM.
// - Sits between the input editor FSM and the parser, which read tokens by index.
//
// PARAMETERS
// - DATA_WIDTH   7    width of one stored element
// - DATA_COUNT   127  capacity in elements (>= 2)
// - INDEX_WIDTH  $clog2(DATA_COUNT)    derived; do not override
// - LENGTH_WIDTH $clog2(DATA_COUNT+1)  derived; do not override
//
// PORTS
// - clk       in   1             single clock, rising edge
// - rst_n     in   1             asynchronous, active-low reset
// - op_valid  in   1             command present
// - op_ready  out  1             block idle, command accepted when op_valid & op_ready
// - op        in   3             OP_GET / OP_SET / OP_INSERT / OP_REMOVE / OP_CLEAR
// - index     in   INDEX_WIDTH   target position, sampled at accept
// - data_in   in   DATA_WIDTH    write data for SET/INSERT, sampled at accept
// - done      out  1             one-cycle pulse, command finished
// - err       out  1             valid with done; 1 = command rejected, no state change
// - data_out  out  DATA_WIDTH    GET result, valid with done, held until next GET completes
// - length    out  LENGTH_WIDTH  current element count
// - full      out  1             length == DATA_COUNT
// - empty     out  1             length == 0
//
// BEHAVIOUR
// - Reset values: op_ready=1, done=0, err=0, data_out=0, length=0. RAM contents are not reset.
// - Accept: cycle T with op_valid & op_ready. index, data_in and op are latched, and op_ready drops at T+1.
// - Error checks use L = length at T:
//   - GET/SET/REMOVE with index >= L -> err.
//   - INSERT with full, or with index > L -> err.
//   - Undefined op code -> err.
// - Error response: done=1, err=1 at T+1. No RAM or length change.
// - GET: RAM read at T; done and data_out at T+1.
// - SET: write mem[index] at T; done at T+1.
// - CLEAR: length<=0; done at T+1. Memory is untouched.
// - INSERT, shift count N = L-index:
//   - For j = L down to index+1: read mem[j-1], write mem[j] one cycle later, fully pipelined.
//   - Then write mem[index]=data_in and set length = L+1.
//   - done at T+N+2. With N=0 (append), done at T+2.
// - REMOVE, shift count N = L-1-index:
//   - For j = index up to L-2: read mem[j+1], write mem[j] one cycle later.
//   - Then set length = L-1.
//   - done at T+N+2. With N=0 (remove last), done at T+2.
// - States:
//   - IDLE -> (accept) CHECK/single-cycle ops -> IDLE.
//   - IDLE -> SHIFT_PRIME (first read) -> SHIFT (read j±1, write j per cycle) -> SHIFT_DRAIN (last write, final data/length update) -> DONE -> IDLE.
//   - When N=0, the path goes straight to the final-write state.
// - Pipeline hazard: a shift never reads the address written in the same cycle, because the read address always leads the write address by 2.
// - length, full and empty update in the done cycle and are stable otherwise.
// - Back-to-back: op_ready rises in the cycle done is pulsed. A new command may be accepted in that same cycle.
// - Reset mid-shift: the FSM aborts to IDLE, length=0, no done pulse. Partially shifted RAM is irrelevant because it is empty.
// - op_valid while not ready is ignored. The command is not queued.
//
// STRUCTURE
// - Package shift_vector_pkg: op_e codes (GET=0, SET=1, INSERT=2, REMOVE=3, CLEAR=4) and the state_e enum.
// - Sub-module vector_ram: DATA_COUNT x DATA_WIDTH, one sync-read port and one write port, no reset.
// - Top level holds the FSM, the j counter, the latched command and the length register.
//
// TESTING
// - Reset, then INSERT idx0..4 values 10..14 (appends) -> each done at T+2, err=0, length=5. GET idx0..4 returns 10..14.
// - From [10..14], INSERT idx1 val 99 -> done at T+6, length=6. GETs read 10,99,11,12,13,14.
// - From that state, REMOVE idx0 -> done at T+7, length=5. GETs read 99,11,12,13,14.
// - Error cases, each with done/err at T+1 and unchanged length/contents:
//   - GET idx5 with length=5.
//   - INSERT idx7 with length=5.
//   - INSERT when full.
//   - REMOVE when empty.
// - Fill to DATA_COUNT with INSERT idx0 each time (worst-case shift), then REMOVE idx0 repeatedly. Check order against a scoreboard; full and empty assert at the boundaries.
// - Assert rst_n mid-INSERT shift -> op_ready=1, length=0, no done. A following GET idx0 returns err=1.

Source files
------------

// File: rtl/shift_vector_pkg.sv
// Shared command codes and FSM states for the shift_vector ordered word list.
package shift_vector_pkg;

    typedef enum logic [2:0] {
        OP_GET    = 3'd0,
        OP_SET    = 3'd1,
        OP_INSERT = 3'd2,
        OP_REMOVE = 3'd3,
        OP_CLEAR  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vector_ram.sv
// Element storage: one synchronous-read port and one write port, contents never reset.
module vector_ram #(
    parameter int DATA_WIDTH  = 7,
    parameter int DATA_COUNT  = 127,
    parameter int INDEX_WIDTH = $clog2(DATA_COUNT)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [INDEX_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    logic [DATA_WIDTH-1:0] mem [DATA_COUNT];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/shift_vector.sv
// Indexed word list with get/set/insert/remove/clear; insert and remove shift
// one element per cycle through the synchronous-read RAM.
module shift_vector
    import shift_vector_pkg::*;
#(
    parameter int DATA_WIDTH   = 7,
    parameter int DATA_COUNT   = 127,
    parameter int INDEX_WIDTH  = $clog2(DATA_COUNT),
    parameter int LENGTH_WIDTH = $clog2(DATA_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2:0]              op,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    done,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [LENGTH_WIDTH-1:0] length,
    output logic                    full,
    output logic                    empty
);

    state_e                  state, state_nx;
    logic                    accept, op_bad, err_r, get_hit;
    logic [LENGTH_WIDTH-1:0] idx_ext, shift_n, cnt;
    logic [INDEX_WIDTH-1:0]  wr_ptr, cmd_index;
    logic [2:0]              cmd_op;
    logic [DATA_WIDTH-1:0]   cmd_data, data_hold, rd_data_p1;
    logic                    ram_we;
    logic [INDEX_WIDTH-1:0]  ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    assign op_ready = (state == ST_IDLE) || (state == ST_RESP) || (state == ST_DONE);
    assign accept   = op_valid && op_ready;
    assign idx_ext  = LENGTH_WIDTH'(index);
    assign full     = (length == LENGTH_WIDTH'(DATA_COUNT));
    assign empty    = (length == '0);
    assign done     = (state == ST_RESP) || (state == ST_DONE);
    assign err      = done && err_r;
    assign get_hit  = (state == ST_RESP) && (cmd_op == OP_GET) && !err_r;
    assign data_out = get_hit ? rd_data_p1 : data_hold;

    always_comb begin
        op_bad  = 1'b0;
        shift_n = length - idx_ext - 1'b1;
        case (op)
            OP_GET, OP_SET, OP_REMOVE: op_bad = (idx_ext >= length);
            OP_INSERT: begin
                op_bad  = full || (idx_ext > length);
                shift_n = length - idx_ext;
            end
            OP_CLEAR:  op_bad = 1'b0;
            default:   op_bad = 1'b1;
        endcase
    end

    // The read address leads the write address by two, so a shift never reads what it writes.
    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = rd_data_p1;
        ram_raddr = (cmd_op == OP_INSERT) ? wr_ptr - 2'd2 : wr_ptr + 2'd2;
        case (state)
            ST_IDLE, ST_RESP, ST_DONE: begin
                state_nx = ST_IDLE;
                if (accept) begin
                    case (op)
                        OP_INSERT: ram_raddr = INDEX_WIDTH'(length - 1'b1);
                        OP_REMOVE: ram_raddr = index + 1'b1;
                        default:   ram_raddr = index;
                    endcase
                    if (op_bad || op == OP_GET || op == OP_SET || op == OP_CLEAR)
                        state_nx = ST_RESP;
                    else
                        state_nx = (shift_n == '0) ? ST_DRAIN : ST_SHIFT;
                    if (!op_bad && op == OP_SET) begin
                        ram_we    = 1'b1;
                        ram_waddr = index;
                        ram_wdata = data_in;
                    end
                end
            end
            ST_SHIFT: begin
                ram_we = 1'b1;
                if (cnt == LENGTH_WIDTH'(1))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nx = ST_DONE;
                if (cmd_op == OP_INSERT) begin
                    ram_we    = 1'b1;
                    ram_waddr = cmd_index;
                    ram_wdata = cmd_data;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            length    <= '0;
            err_r     <= 1'b0;
            data_hold <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                err_r <= op_bad;
            if (accept && !op_bad && op == OP_CLEAR)
                length <= '0;
            else if (state == ST_DRAIN)
                length <= (cmd_op == OP_INSERT) ? length + 1'b1 : length - 1'b1;
            if (get_hit)
                data_hold <= rd_data_p1;
        end
    end

    // Latched command and shift bookkeeping carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_op    <= op;
            cmd_index <= index;
            cmd_data  <= data_in;
            cnt       <= shift_n;
            wr_ptr    <= (op == OP_INSERT) ? INDEX_WIDTH'(length) : index;
        end else if (state == ST_SHIFT) begin
            cnt    <= cnt - 1'b1;
            wr_ptr <= (cmd_op == OP_INSERT) ? wr_ptr - 1'b1 : wr_ptr + 1'b1;
        end
    end

    vector_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_COUNT (DATA_COUNT),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(ram_wdata),
        .rd_addr(ram_raddr),
        .rd_data(rd_data_p1)
    );

endmodule

// File: tb/tb_shift_vector.sv
// Randomised and directed bench for shift_vector against a queue-based list model.
module tb_shift_vector;
    import shift_vector_pkg::*;

    localparam int DW = 7;
    localparam int DC = 127;
    localparam int IW = $clog2(DC);
    localparam int LW = $clog2(DC + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [2:0]    op = 3'd0;
    logic [IW-1:0] index = '0;
    logic [DW-1:0] data_in = '0;
    logic          done, err, full, empty;
    logic [DW-1:0] data_out;
    logic [LW-1:0] length;

    int n_cmp = 0;
    int n_bad = 0;
    int model_q[$];
    int last_dout = 0;

    always #5 clk = ~clk;

    shift_vector #(.DATA_WIDTH(DW), .DATA_COUNT(DC)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .index(index), .data_in(data_in), .done(done), .err(err),
        .data_out(data_out), .length(length), .full(full), .empty(empty)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Issue one command, compare its response against the list model.
    task automatic do_op(input logic [2:0] o, input logic [IW-1:0] idx,
                         input logic [DW-1:0] din, input string tag);
        int L, exp_lat, lat, wait_n, exp_dout;
        bit exp_err;
        L = model_q.size();
        exp_err = 1'b0;
        exp_lat = 1;
        exp_dout = last_dout;
        case (o)
            OP_GET:    if (int'(idx) >= L) exp_err = 1'b1; else exp_dout = model_q[idx];
            OP_SET:    if (int'(idx) >= L) exp_err = 1'b1; else model_q[idx] = din;
            OP_INSERT: if (L == DC || int'(idx) > L) exp_err = 1'b1;
                       else begin exp_lat = L - int'(idx) + 2; model_q.insert(idx, din); end
            OP_REMOVE: if (int'(idx) >= L) exp_err = 1'b1;
                       else begin exp_lat = L - 1 - int'(idx) + 2; model_q.delete(idx); end
            OP_CLEAR:  model_q.delete();
            default:   exp_err = 1'b1;
        endcase
        wait_n = 0;
        while (!op_ready && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        if (!op_ready) check_val({tag, " ready_timeout"}, 0, 1);
        op_valid = 1'b1;
        op = o;
        index = idx;
        data_in = din;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 300 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
        check_val({tag, " latency"}, lat, exp_lat);
        check_val({tag, " err"}, int'(err), int'(exp_err));
        if (!(o == OP_GET && exp_err)) begin
            check_val({tag, " data_out"}, int'(data_out), exp_dout);
            last_dout = exp_dout;
        end
        check_val({tag, " length"}, int'(length), model_q.size());
        check_val({tag, " full"}, int'(full), int'(model_q.size() == DC));
        check_val({tag, " empty"}, int'(empty), int'(model_q.size() == 0));
    endtask

    task automatic get_all(input string tag);
        for (int i = 0; i < model_q.size(); i++)
            do_op(OP_GET, IW'(i), '0, tag);
    endtask

    initial begin
        int L, r, no_done;
        logic [IW-1:0] ri;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset op_ready", int'(op_ready), 1);
        check_val("reset done", int'(done), 0);
        check_val("reset err", int'(err), 0);
        check_val("reset data_out", int'(data_out), 0);
        check_val("reset length", int'(length), 0);
        check_val("reset empty", int'(empty), 1);
        check_val("reset full", int'(full), 0);

        for (int i = 0; i < 5; i++) do_op(OP_INSERT, IW'(i), DW'(10 + i), "append");
        get_all("get_after_append");
        do_op(OP_INSERT, 7'd1, 7'd99, "insert_mid");
        get_all("get_after_insert");
        do_op(OP_REMOVE, 7'd0, '0, "remove_head");
        get_all("get_after_remove");
        do_op(OP_GET, 7'd5, '0, "err_get_oob");
        do_op(OP_INSERT, 7'd7, 7'd55, "err_insert_oob");
        do_op(OP_SET, 7'd2, 7'd77, "set_mid");
        do_op(3'd6, 7'd0, '0, "err_bad_op");
        get_all("get_after_errors");
        do_op(OP_CLEAR, '0, '0, "clear");
        do_op(OP_REMOVE, 7'd0, '0, "err_remove_empty");

        for (int i = 0; i < DC; i++) do_op(OP_INSERT, 7'd0, DW'($urandom), "fill_head");
        do_op(OP_INSERT, 7'd0, 7'd1, "err_insert_full");
        do_op(OP_GET, 7'd126, '0, "get_last_full");
        for (int i = 0; i < DC; i++) begin
            do_op(OP_GET, 7'd0, '0, "drain_get");
            do_op(OP_REMOVE, 7'd0, '0, "drain_remove");
        end

        for (int n = 0; n < 200; n++) begin
            L = model_q.size();
            r = $urandom_range(0, 19);
            ri = IW'($urandom_range(0, (L + 1 > DC - 1) ? DC - 1 : L + 1));
            if (r < 5)       do_op(OP_GET, ri, '0, "rnd_get");
            else if (r < 8)  do_op(OP_SET, ri, DW'($urandom), "rnd_set");
            else if (r < 13) do_op(OP_INSERT, ri, DW'($urandom), "rnd_insert");
            else if (r < 17) do_op(OP_REMOVE, ri, '0, "rnd_remove");
            else if (r < 18) do_op(OP_CLEAR, '0, '0, "rnd_clear");
            else             do_op(3'($urandom_range(5, 7)), ri, '0, "rnd_bad_op");
        end
        get_all("get_after_random");

        do_op(OP_CLEAR, '0, '0, "pre_abort_clear");
        for (int i = 0; i < 20; i++) do_op(OP_INSERT, 7'd0, DW'($urandom), "pre_abort_fill");
        op_valid = 1'b1;
        op = OP_INSERT;
        index = '0;
        data_in = 7'd33;
        @(posedge clk);
        #1 op_valid = 1'b0;
        no_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) no_done++;
        end
        rst_n = 1'b0;
        #1;
        check_val("abort op_ready", int'(op_ready), 1);
        check_val("abort length", int'(length), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) no_done++;
        end
        check_val("abort done_pulses", no_done, 0);
        model_q.delete();
        last_dout = 0;
        do_op(OP_GET, 7'd0, '0, "err_get_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
